// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read-port arbiter: grants IC or DC one AR transaction at a time
// and steers the R burst back to the granted master until its last beat.
module axi_rd_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic [ADDR_W-1:0] I_ic_araddr,
    input  logic              I_ic_arvalid,
    input  logic [7:0]        I_ic_arlen,
    input  logic [2:0]        I_ic_arsize,
    input  logic [1:0]        I_ic_arburst,
    output logic              O_ic_arready,
    input  logic              I_ic_rready,
    output logic [DATA_W-1:0] O_ic_rdata,
    output logic              O_ic_rvalid,
    output logic              O_ic_rlast,
    input  logic [ADDR_W-1:0] I_dc_araddr,
    input  logic              I_dc_arvalid,
    input  logic [7:0]        I_dc_arlen,
    input  logic [2:0]        I_dc_arsize,
    input  logic [1:0]        I_dc_arburst,
    output logic              O_dc_arready,
    input  logic              I_dc_rready,
    output logic [DATA_W-1:0] O_dc_rdata,
    output logic              O_dc_rvalid,
    output logic              O_dc_rlast,
    output logic [ADDR_W-1:0] O_mem_araddr,
    output logic              O_mem_arvalid,
    output logic [7:0]        O_mem_arlen,
    output logic [2:0]        O_mem_arsize,
    output logic [1:0]        O_mem_arburst,
    input  logic              I_mem_arready,
    input  logic [DATA_W-1:0] I_mem_rdata,
    input  logic              I_mem_rvalid,
    input  logic              I_mem_rlast,
    output logic              O_mem_rready,
    output logic              O_busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        AR_IC = 3'd1,
        AR_DC = 3'd2,
        R_IC  = 3'd3,
        R_DC  = 3'd4
    } state_t;

    state_t state, state_nxt;
    // last_dc = 1 when the most recent AR handshake belonged to DC
    logic   last_dc, last_dc_nxt;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state   <= IDLE;
            last_dc <= 1'b0;
        end else begin
            state   <= state_nxt;
            last_dc <= last_dc_nxt;
        end
    end

    // Arbitration and burst tracking; grant is held until the last R beat is accepted
    always_comb begin
        state_nxt   = state;
        last_dc_nxt = last_dc;
        unique case (state)
            IDLE: begin
                if (I_ic_arvalid && I_dc_arvalid)
                    state_nxt = (RR_EN && last_dc) ? AR_IC : AR_DC;
                else if (I_dc_arvalid)
                    state_nxt = AR_DC;
                else if (I_ic_arvalid)
                    state_nxt = AR_IC;
            end
            AR_IC: begin
                if (I_mem_arready) begin
                    state_nxt   = R_IC;
                    last_dc_nxt = 1'b0;
                end
            end
            AR_DC: begin
                if (I_mem_arready) begin
                    state_nxt   = R_DC;
                    last_dc_nxt = 1'b1;
                end
            end
            R_IC: begin
                if (I_mem_rvalid && I_ic_rready && I_mem_rlast)
                    state_nxt = IDLE;
            end
            R_DC: begin
                if (I_mem_rvalid && I_dc_rready && I_mem_rlast)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Channel steering; everything not owned by the current state is driven to zero
    always_comb begin
        O_ic_arready  = 1'b0;
        O_ic_rdata    = '0;
        O_ic_rvalid   = 1'b0;
        O_ic_rlast    = 1'b0;
        O_dc_arready  = 1'b0;
        O_dc_rdata    = '0;
        O_dc_rvalid   = 1'b0;
        O_dc_rlast    = 1'b0;
        O_mem_araddr  = '0;
        O_mem_arvalid = 1'b0;
        O_mem_arlen   = '0;
        O_mem_arsize  = '0;
        O_mem_arburst = '0;
        O_mem_rready  = 1'b0;
        O_busy        = (state != IDLE);
        unique case (state)
            AR_IC: begin
                O_mem_araddr  = I_ic_araddr;
                O_mem_arvalid = 1'b1;
                O_mem_arlen   = I_ic_arlen;
                O_mem_arsize  = I_ic_arsize;
                O_mem_arburst = I_ic_arburst;
                O_ic_arready  = I_mem_arready;
            end
            AR_DC: begin
                O_mem_araddr  = I_dc_araddr;
                O_mem_arvalid = 1'b1;
                O_mem_arlen   = I_dc_arlen;
                O_mem_arsize  = I_dc_arsize;
                O_mem_arburst = I_dc_arburst;
                O_dc_arready  = I_mem_arready;
            end
            R_IC: begin
                O_ic_rdata   = I_mem_rdata;
                O_ic_rvalid  = I_mem_rvalid;
                O_ic_rlast   = I_mem_rlast;
                O_mem_rready = I_ic_rready;
            end
            R_DC: begin
                O_dc_rdata   = I_mem_rdata;
                O_dc_rvalid  = I_mem_rvalid;
                O_dc_rlast   = I_mem_rlast;
                O_mem_rready = I_dc_rready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a round-robin instance plus a fixed-priority
// instance sharing the same stimulus.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ic_araddr, dc_araddr;
    logic        ic_arvalid, dc_arvalid;
    logic [7:0]  ic_arlen, dc_arlen;
    logic [2:0]  ic_arsize, dc_arsize;
    logic [1:0]  ic_arburst, dc_arburst;
    logic        ic_rready, dc_rready;
    logic        mem_arready, mem_rvalid, mem_rlast;
    logic [63:0] mem_rdata;

    logic        ic_arready, ic_rvalid, ic_rlast, dc_arready, dc_rvalid, dc_rlast;
    logic [63:0] ic_rdata, dc_rdata;
    logic [31:0] mem_araddr;
    logic        mem_arvalid, mem_rready, busy;
    logic [7:0]  mem_arlen;
    logic [2:0]  mem_arsize;
    logic [1:0]  mem_arburst;

    logic        fp_ic_arready, fp_ic_rvalid, fp_ic_rlast, fp_dc_arready, fp_dc_rvalid, fp_dc_rlast;
    logic [63:0] fp_ic_rdata, fp_dc_rdata;
    logic [31:0] fp_mem_araddr;
    logic        fp_mem_arvalid, fp_mem_rready, fp_busy;
    logic [7:0]  fp_mem_arlen;
    logic [2:0]  fp_mem_arsize;
    logic [1:0]  fp_mem_arburst;

    logic [181:0] dut_outs, fp_outs;
    assign dut_outs = {ic_arready, ic_rdata, ic_rvalid, ic_rlast, dc_arready, dc_rdata, dc_rvalid,
                       dc_rlast, mem_araddr, mem_arvalid, mem_arlen, mem_arsize, mem_arburst,
                       mem_rready, busy};
    assign fp_outs  = {fp_ic_arready, fp_ic_rdata, fp_ic_rvalid, fp_ic_rlast, fp_dc_arready,
                       fp_dc_rdata, fp_dc_rvalid, fp_dc_rlast, fp_mem_araddr, fp_mem_arvalid,
                       fp_mem_arlen, fp_mem_arsize, fp_mem_arburst, fp_mem_rready, fp_busy};

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(64), .RR_EN(1'b1)) dut (
        .I_clk(clk), .I_rst(rst),
        .I_ic_araddr(ic_araddr), .I_ic_arvalid(ic_arvalid), .I_ic_arlen(ic_arlen),
        .I_ic_arsize(ic_arsize), .I_ic_arburst(ic_arburst), .O_ic_arready(ic_arready),
        .I_ic_rready(ic_rready), .O_ic_rdata(ic_rdata), .O_ic_rvalid(ic_rvalid), .O_ic_rlast(ic_rlast),
        .I_dc_araddr(dc_araddr), .I_dc_arvalid(dc_arvalid), .I_dc_arlen(dc_arlen),
        .I_dc_arsize(dc_arsize), .I_dc_arburst(dc_arburst), .O_dc_arready(dc_arready),
        .I_dc_rready(dc_rready), .O_dc_rdata(dc_rdata), .O_dc_rvalid(dc_rvalid), .O_dc_rlast(dc_rlast),
        .O_mem_araddr(mem_araddr), .O_mem_arvalid(mem_arvalid), .O_mem_arlen(mem_arlen),
        .O_mem_arsize(mem_arsize), .O_mem_arburst(mem_arburst), .I_mem_arready(mem_arready),
        .I_mem_rdata(mem_rdata), .I_mem_rvalid(mem_rvalid), .I_mem_rlast(mem_rlast),
        .O_mem_rready(mem_rready), .O_busy(busy)
    );

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(64), .RR_EN(1'b0)) dut_fp (
        .I_clk(clk), .I_rst(rst),
        .I_ic_araddr(ic_araddr), .I_ic_arvalid(ic_arvalid), .I_ic_arlen(ic_arlen),
        .I_ic_arsize(ic_arsize), .I_ic_arburst(ic_arburst), .O_ic_arready(fp_ic_arready),
        .I_ic_rready(ic_rready), .O_ic_rdata(fp_ic_rdata), .O_ic_rvalid(fp_ic_rvalid),
        .O_ic_rlast(fp_ic_rlast),
        .I_dc_araddr(dc_araddr), .I_dc_arvalid(dc_arvalid), .I_dc_arlen(dc_arlen),
        .I_dc_arsize(dc_arsize), .I_dc_arburst(dc_arburst), .O_dc_arready(fp_dc_arready),
        .I_dc_rready(dc_rready), .O_dc_rdata(fp_dc_rdata), .O_dc_rvalid(fp_dc_rvalid),
        .O_dc_rlast(fp_dc_rlast),
        .O_mem_araddr(fp_mem_araddr), .O_mem_arvalid(fp_mem_arvalid), .O_mem_arlen(fp_mem_arlen),
        .O_mem_arsize(fp_mem_arsize), .O_mem_arburst(fp_mem_arburst), .I_mem_arready(mem_arready),
        .I_mem_rdata(mem_rdata), .I_mem_rvalid(mem_rvalid), .I_mem_rlast(mem_rlast),
        .O_mem_rready(fp_mem_rready), .O_busy(fp_busy)
    );

    // Inputs change 1 time unit after the rising edge; checks sample 1 unit later still
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ic_araddr = '0; ic_arvalid = 1'b0; ic_arlen = '0; ic_arsize = '0; ic_arburst = '0;
        dc_araddr = '0; dc_arvalid = 1'b0; dc_arlen = '0; dc_arsize = '0; dc_arburst = '0;
        ic_rready = 1'b1; dc_rready = 1'b1;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_beat(input logic [63:0] data, input logic last);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        mem_rlast  = last;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        ic_arvalid = 1'b1; dc_arvalid = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF;
        tick(); tick();
        #1;
        total++;
        if (dut_outs !== '0) $display("FAIL reset_outs: got %h want 0", dut_outs); else passed++;
        total++;
        if (fp_outs !== '0) $display("FAIL reset_fp_outs: got %h want 0", fp_outs); else passed++;
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_ic_only();
        logic [63:0] exp;
        do_reset();
        ic_araddr = 32'h8000_0020; ic_arlen = 8'd3; ic_arsize = 3'd3; ic_arburst = 2'd1;
        ic_arvalid = 1'b1;
        #1;
        total++;
        if ({mem_arvalid, busy} !== 2'b00)
            $display("FAIL ic_req_cycle0: got %b want 00", {mem_arvalid, busy}); else passed++;
        tick();
        mem_arready = 1'b1;
        #1;
        total++;
        if ({mem_arvalid, mem_araddr, mem_arlen, mem_arsize, mem_arburst, ic_arready, dc_arready, busy}
            !== {1'b1, 32'h8000_0020, 8'd3, 3'd3, 2'd1, 1'b1, 1'b0, 1'b1})
            $display("FAIL ic_ar_fwd: got %h %h %h %h %h ird=%b drd=%b", mem_arvalid, mem_araddr,
                     mem_arlen, mem_arsize, mem_arburst, ic_arready, dc_arready);
        else passed++;
        tick();
        ic_arvalid = 1'b0; mem_arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = 64'hA0 + 64'(i);
            set_beat(exp, i == 3);
            #1;
            total++;
            if ({ic_rvalid, ic_rdata, ic_rlast, dc_rvalid, mem_rready, mem_arvalid}
                !== {1'b1, exp, (i == 3), 1'b0, 1'b1, 1'b0})
                $display("FAIL ic_beat%0d: got v=%b d=%h l=%b dcv=%b rr=%b want d=%h", i, ic_rvalid,
                         ic_rdata, ic_rlast, dc_rvalid, mem_rready, exp);
            else passed++;
            tick();
        end
        idle_inputs();
        #1;
        total++;
        if ({busy, ic_rvalid, mem_rready} !== 3'b000)
            $display("FAIL ic_done_idle: got %b want 000", {busy, ic_rvalid, mem_rready}); else passed++;
    endtask

    task automatic test_round_robin();
        do_reset();
        mem_arready = 1'b1;
        ic_araddr = 32'h2000; ic_arlen = 8'd1; ic_arvalid = 1'b1;
        dc_araddr = 32'h1000; dc_arlen = 8'd1; dc_arvalid = 1'b1;
        tick();
        #1;
        total++;
        if ({mem_araddr, dc_arready, ic_arready} !== {32'h1000, 1'b1, 1'b0})
            $display("FAIL rr_first_dc: got %h drd=%b ird=%b want 1000", mem_araddr, dc_arready, ic_arready);
        else passed++;
        tick();
        dc_arvalid = 1'b0;
        set_beat(64'h11, 1'b0);
        #1;
        total++;
        if ({dc_rvalid, dc_rdata, ic_rvalid, ic_rdata} !== {1'b1, 64'h11, 1'b0, 64'h0})
            $display("FAIL rr_dc_beat: got dcv=%b dcd=%h icv=%b icd=%h", dc_rvalid, dc_rdata, ic_rvalid, ic_rdata);
        else passed++;
        tick();
        set_beat(64'h12, 1'b1);
        tick();
        mem_rvalid = 1'b0; mem_rlast = 1'b0;
        #1;
        total++;
        if ({busy, mem_arvalid} !== 2'b00)
            $display("FAIL rr_idle_gap: got %b want 00", {busy, mem_arvalid}); else passed++;
        tick();
        #1;
        total++;
        if ({mem_araddr, ic_arready, dc_arready} !== {32'h2000, 1'b1, 1'b0})
            $display("FAIL rr_then_ic: got %h ird=%b drd=%b want 2000", mem_araddr, ic_arready, dc_arready);
        else passed++;
        tick();
        ic_arvalid = 1'b0;
        set_beat(64'h21, 1'b0);
        tick();
        set_beat(64'h22, 1'b1);
        tick();
        mem_rvalid = 1'b0; mem_rlast = 1'b0;
        ic_arvalid = 1'b1; dc_arvalid = 1'b1;
        tick();
        #1;
        total++;
        if ({mem_araddr, dc_arready} !== {32'h1000, 1'b1})
            $display("FAIL rr_second_tie: got %h drd=%b want 1000", mem_araddr, dc_arready); else passed++;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        mem_arready = 1'b1;
        ic_araddr = 32'h2000; ic_arvalid = 1'b1;
        dc_araddr = 32'h1000; dc_arvalid = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            #1;
            total++;
            if ({fp_mem_araddr, fp_dc_arready, fp_ic_arready} !== {32'h1000, 1'b1, 1'b0})
                $display("FAIL fp_round%0d_grant: got %h drd=%b ird=%b want 1000", r, fp_mem_araddr,
                         fp_dc_arready, fp_ic_arready);
            else passed++;
            tick();
            set_beat(64'h40 + 64'(r), 1'b1);
            #1;
            total++;
            if ({fp_dc_rvalid, fp_dc_rlast, fp_ic_rvalid} !== 3'b110)
                $display("FAIL fp_round%0d_beat: got %b want 110", r, {fp_dc_rvalid, fp_dc_rlast, fp_ic_rvalid});
            else passed++;
            tick();
            mem_rvalid = 1'b0; mem_rlast = 1'b0;
        end
        dc_arvalid = 1'b0;
        tick();
        #1;
        total++;
        if ({fp_mem_araddr, fp_ic_arready} !== {32'h2000, 1'b1})
            $display("FAIL fp_ic_after_dc: got %h ird=%b want 2000", fp_mem_araddr, fp_ic_arready); else passed++;
    endtask

    task automatic test_ar_stall();
        do_reset();
        ic_araddr = 32'h3000; ic_arlen = 8'd3; ic_arsize = 3'd3; ic_arburst = 2'd1; ic_arvalid = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if ({mem_arvalid, mem_araddr, mem_arlen, mem_arsize, mem_arburst, ic_arready}
                !== {1'b1, 32'h3000, 8'd3, 3'd3, 2'd1, 1'b0})
                $display("FAIL ar_stall_c%0d: got v=%b a=%h len=%h ird=%b", c, mem_arvalid, mem_araddr,
                         mem_arlen, ic_arready);
            else passed++;
            tick();
        end
        mem_arready = 1'b1;
        #1;
        total++;
        if (ic_arready !== 1'b1) $display("FAIL ar_stall_hs: got %b want 1", ic_arready); else passed++;
        tick();
        ic_arvalid = 1'b0; mem_arready = 1'b0;
        #1;
        total++;
        if ({busy, mem_arvalid, mem_rready} !== 3'b101)
            $display("FAIL ar_stall_r_ic: got %b want 101", {busy, mem_arvalid, mem_rready}); else passed++;
    endtask

    task automatic test_rready_stall();
        int k = 0;
        do_reset();
        mem_arready = 1'b1;
        ic_araddr = 32'h4000; ic_arlen = 8'd3; ic_arvalid = 1'b1;
        tick(); tick();
        ic_arvalid = 1'b0; mem_arready = 1'b0;
        for (int c = 0; c < 10 && k < 4; c++) begin
            ic_rready = (c != 2 && c != 3);
            set_beat(64'(k), k == 3);
            #1;
            total++;
            if ({ic_rvalid, ic_rdata, ic_rlast, mem_rready} !== {1'b1, 64'(k), (k == 3), ic_rready})
                $display("FAIL rready_c%0d: got v=%b d=%h l=%b rr=%b want d=%h rr=%b", c, ic_rvalid,
                         ic_rdata, ic_rlast, mem_rready, 64'(k), ic_rready);
            else passed++;
            tick();
            if (ic_rready) k++;
        end
        idle_inputs();
        #1;
        total++;
        if ({k, busy} !== {32'd4, 1'b0})
            $display("FAIL rready_done: got beats=%0d busy=%b want 4/0", k, busy); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_arready = 1'b1;
        dc_araddr = 32'h5000; dc_arlen = 8'd3; dc_arvalid = 1'b1;
        tick(); tick();
        dc_arvalid = 1'b0; mem_arready = 1'b0;
        set_beat(64'h50, 1'b0);
        tick();
        set_beat(64'h51, 1'b0);
        rst = 1'b1;
        #1;
        total++;
        if ({dc_rvalid, dc_rdata} !== {1'b1, 64'h51})
            $display("FAIL rstmid_pre: got v=%b d=%h want 1/51", dc_rvalid, dc_rdata); else passed++;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (dut_outs !== '0) $display("FAIL rstmid_outs: got %h want 0", dut_outs); else passed++;
        idle_inputs();
        ic_araddr = 32'h6000; ic_arvalid = 1'b1;
        dc_araddr = 32'h7000; dc_arvalid = 1'b1;
        tick();
        #1;
        total++;
        if ({mem_araddr, dc_arready, mem_arvalid} !== {32'h7000, 1'b0, 1'b1})
            $display("FAIL rstmid_lastgrant: got %h want 7000 (DC wins a tie)", mem_araddr); else passed++;
        do_reset();
        ic_araddr = 32'h6000; ic_arvalid = 1'b1; mem_arready = 1'b1;
        tick();
        #1;
        total++;
        if ({mem_araddr, ic_arready} !== {32'h6000, 1'b1})
            $display("FAIL rstmid_fresh_ar: got %h ird=%b want 6000", mem_araddr, ic_arready); else passed++;
        tick();
        ic_arvalid = 1'b0; mem_arready = 1'b0;
        set_beat(64'h66, 1'b1);
        #1;
        total++;
        if ({ic_rvalid, ic_rdata, ic_rlast} !== {1'b1, 64'h66, 1'b1})
            $display("FAIL rstmid_fresh_r: got v=%b d=%h l=%b", ic_rvalid, ic_rdata, ic_rlast); else passed++;
        tick();
        idle_inputs();
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL rstmid_fresh_idle: got %b want 0", busy); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ic_only();
        test_round_robin();
        test_fixed_priority();
        test_ar_stall();
        test_rready_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
